// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: two Avalon-MM managers (instruction, read-only, and data,
// read/write) share one pipelined memory port. Only one transaction is in
// flight at a time, and read data valid is steered back to the manager that
// owns the outstanding read.
module avalon_bus_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_address,
    input  logic [3:0]  instr_byteenable,
    input  logic        instr_read,
    output logic        instr_waitrequest,
    output logic [31:0] instr_agent_to_host,
    output logic        instr_readdatavalid,
    input  logic [31:0] data_address,
    input  logic [3:0]  data_byteenable,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_host_to_agent,
    output logic        data_waitrequest,
    output logic [31:0] data_agent_to_host,
    output logic        data_readdatavalid,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_host_to_agent,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_agent_to_host,
    input  logic        mem_readdatavalid,
    output logic        bus_error
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_READ = 2'd2;

    localparam logic GNT_INSTR = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    logic [1:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic       bus_error_q, bus_error_d;

    logic       instr_req;
    logic       data_req;
    logic       arb_grant;
    logic       gnt_strobe;
    logic       gnt_is_write;
    logic       in_issue;
    logic       in_wait;

    // Request decode and arbitration; read+write together counts as a write.
    always_comb begin
        instr_req    = instr_read;
        data_req     = data_read | data_write;
        if (instr_req && data_req) begin
            arb_grant = (ROUND_ROBIN != 0) ? ~last_grant_q : GNT_DATA;
        end else begin
            arb_grant = data_req ? GNT_DATA : GNT_INSTR;
        end
        gnt_strobe   = grant_q ? data_req : instr_req;
        gnt_is_write = grant_q & data_write;
    end

    // Next-state logic for the one-outstanding-transaction FSM.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        // A valid beat is only expected while waiting for read data.
        bus_error_d  = bus_error_q |
                       (mem_readdatavalid && (state_q == ST_IDLE || state_q == ST_ISSUE));
        case (state_q)
            ST_IDLE: begin
                if (instr_req || data_req) begin
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!gnt_strobe) begin
                    state_d = ST_IDLE;
                end else if (!mem_waitrequest) begin
                    state_d = gnt_is_write ? ST_IDLE : ST_WAIT_READ;
                end
            end
            ST_WAIT_READ: begin
                if (mem_readdatavalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any outstanding read immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_INSTR;
            last_grant_q <= GNT_INSTR;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // Shared-port drive and upstream handshake, all decoded from the state.
    always_comb begin
        in_issue = (state_q == ST_ISSUE);
        in_wait  = (state_q == ST_WAIT_READ);

        mem_read          = in_issue & (grant_q ? (data_read & ~data_write) : instr_read);
        mem_write         = in_issue & grant_q & data_write;
        mem_address       = in_issue ? (grant_q ? data_address : instr_address) : 32'h0;
        mem_byteenable    = in_issue ? (grant_q ? data_byteenable : instr_byteenable) : 4'h0;
        mem_host_to_agent = (in_issue && grant_q) ? data_host_to_agent : 32'h0;

        instr_waitrequest = ~(in_issue & (grant_q == GNT_INSTR) & ~mem_waitrequest);
        data_waitrequest  = ~(in_issue & (grant_q == GNT_DATA) & ~mem_waitrequest);

        instr_readdatavalid = in_wait & mem_readdatavalid & (grant_q == GNT_INSTR);
        data_readdatavalid  = in_wait & mem_readdatavalid & (grant_q == GNT_DATA);

        instr_agent_to_host = mem_agent_to_host;
        data_agent_to_host  = mem_agent_to_host;

        bus_error = bus_error_q;
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: a round-robin instance driven by vector table
// and hand sequences, plus a fixed-priority instance checked under contention.
module tb_avalon_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] instr_address = '0;
    logic [3:0]  instr_byteenable = '0;
    logic        instr_read = 1'b0;
    logic [31:0] data_address = '0;
    logic [3:0]  data_byteenable = '0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_host_to_agent = '0;

    logic        mem_wait = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rdv_force = 1'b0;
    logic        auto_en = 1'b0;
    logic        rdv_auto_q = 1'b0;
    logic        r_mem_rdv;

    logic        r_instr_wait, r_instr_rdv, r_data_wait, r_data_rdv;
    logic [31:0] r_instr_rdata, r_data_rdata, r_mem_addr, r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        r_mem_read, r_mem_write, r_bus_error;

    logic        f_instr_wait, f_instr_rdv, f_data_wait, f_data_rdv;
    logic [31:0] f_instr_rdata, f_data_rdata, f_mem_addr, f_mem_wdata;
    logic [3:0]  f_mem_be;
    logic        f_mem_read, f_mem_write, f_bus_error;
    logic        f_rdv_q = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign r_mem_rdv = rdv_auto_q | rdv_force;

    // Simple slave models: read data valid one cycle after a zero-wait accept.
    always @(posedge clk) begin
        rdv_auto_q <= auto_en & r_mem_read & ~mem_wait;
        f_rdv_q    <= f_mem_read;
    end

    avalon_bus_arbiter #(.ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst(rst),
        .instr_address(instr_address), .instr_byteenable(instr_byteenable),
        .instr_read(instr_read), .instr_waitrequest(r_instr_wait),
        .instr_agent_to_host(r_instr_rdata), .instr_readdatavalid(r_instr_rdv),
        .data_address(data_address), .data_byteenable(data_byteenable),
        .data_read(data_read), .data_write(data_write),
        .data_host_to_agent(data_host_to_agent), .data_waitrequest(r_data_wait),
        .data_agent_to_host(r_data_rdata), .data_readdatavalid(r_data_rdv),
        .mem_address(r_mem_addr), .mem_byteenable(r_mem_be),
        .mem_read(r_mem_read), .mem_write(r_mem_write),
        .mem_host_to_agent(r_mem_wdata), .mem_waitrequest(mem_wait),
        .mem_agent_to_host(mem_rdata), .mem_readdatavalid(r_mem_rdv),
        .bus_error(r_bus_error)
    );

    avalon_bus_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .clk(clk), .rst(rst),
        .instr_address(instr_address), .instr_byteenable(instr_byteenable),
        .instr_read(instr_read), .instr_waitrequest(f_instr_wait),
        .instr_agent_to_host(f_instr_rdata), .instr_readdatavalid(f_instr_rdv),
        .data_address(data_address), .data_byteenable(data_byteenable),
        .data_read(data_read), .data_write(data_write),
        .data_host_to_agent(data_host_to_agent), .data_waitrequest(f_data_wait),
        .data_agent_to_host(f_data_rdata), .data_readdatavalid(f_data_rdv),
        .mem_address(f_mem_addr), .mem_byteenable(f_mem_be),
        .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_host_to_agent(f_mem_wdata), .mem_waitrequest(1'b0),
        .mem_agent_to_host(mem_rdata), .mem_readdatavalid(f_rdv_q),
        .bus_error(f_bus_error)
    );

    typedef struct {
        logic        ir;
        logic        dr;
        logic        dw;
        logic [31:0] ia;
        logic [3:0]  ib;
        logic [31:0] da;
        logic [3:0]  db;
        logic [31:0] wd;
        logic        eg;   // expected grant: 0 instr, 1 data
        logic        erd;
        logic        ewr;
        logic [31:0] ea;
        logic [3:0]  eb;
        logic [31:0] ewd;
    } vec_t;

    vec_t vt [7];
    logic q_rr [$];
    logic q_fp [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        instr_read = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    // Observed grant on the round-robin instance as {data, instr} one-hot.
    function automatic logic [1:0] obs_r();
        return {~r_data_wait, ~r_instr_wait};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [1:0]  onehot;
        logic [31:0] rd;
        int stable, low, n_rr, n_fp;

        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 4'hF, 32'h0,   4'h0, 32'h0,
                  1'b0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0,   4'h0, 32'h200, 4'h3, 32'h0,
                  1'b1, 1'b1, 1'b0, 32'h200, 4'h3, 32'h0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 32'h0,   4'h0, 32'h300, 4'hC, 32'hA5A55A5A,
                  1'b1, 1'b0, 1'b1, 32'h300, 4'hC, 32'hA5A55A5A};
        vt[3] = '{1'b1, 1'b0, 1'b1, 32'h400, 4'hF, 32'h500, 4'hF, 32'h0BADF00D,
                  1'b0, 1'b1, 1'b0, 32'h400, 4'hF, 32'h0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 32'h600, 4'hF, 32'h700, 4'h1, 32'h0,
                  1'b1, 1'b1, 1'b0, 32'h700, 4'h1, 32'h0};
        vt[5] = '{1'b0, 1'b1, 1'b1, 32'h0,   4'h0, 32'h800, 4'hF, 32'h11,
                  1'b1, 1'b0, 1'b1, 32'h800, 4'hF, 32'h11};
        vt[6] = '{1'b1, 1'b0, 1'b1, 32'h900, 4'h3, 32'hA00, 4'h6, 32'h22,
                  1'b0, 1'b1, 1'b0, 32'h900, 4'h3, 32'h0};

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_strobes", {30'd0, r_mem_read, r_mem_write}, 32'd0);
        chk("rst_addr", r_mem_addr, 32'd0);
        chk("rst_wait", {30'd0, r_instr_wait, r_data_wait}, 32'd3);
        chk("rst_rdv_err", {29'd0, r_instr_rdv, r_data_rdv, r_bus_error}, 32'd0);
        rst = 1'b1;
        tick();

        // Table-driven single transactions on the round-robin instance
        for (int i = 0; i < 7; i++) begin
            mem_wait           = 1'b0;
            instr_read         = vt[i].ir;
            instr_address      = vt[i].ia;
            instr_byteenable   = vt[i].ib;
            data_read          = vt[i].dr;
            data_write         = vt[i].dw;
            data_address       = vt[i].da;
            data_byteenable    = vt[i].db;
            data_host_to_agent = vt[i].wd;
            q_rr.push_back(vt[i].eg);
            #1;
            chk("idle_strobes", {30'd0, r_mem_read, r_mem_write}, 32'd0);
            chk("idle_wait", {30'd0, r_instr_wait, r_data_wait}, 32'd3);
            tick();
            chk("iss_read", {31'd0, r_mem_read}, {31'd0, vt[i].erd});
            chk("iss_write", {31'd0, r_mem_write}, {31'd0, vt[i].ewr});
            chk("iss_addr", r_mem_addr, vt[i].ea);
            chk("iss_be", {28'd0, r_mem_be}, {28'd0, vt[i].eb});
            chk("iss_wdata", r_mem_wdata, vt[i].ewd);
            if (q_rr.size() == 0) begin
                chk("grant_queue_empty", 32'd0, 32'd1);
            end else begin
                e = q_rr.pop_front();
                onehot = e ? 2'b10 : 2'b01;
                chk("grant", {30'd0, obs_r()}, {30'd0, onehot});
            end
            tick();
            drop_all();
            #1;
            chk("post_accept_strobes", {30'd0, r_mem_read, r_mem_write}, 32'd0);
            if (vt[i].erd) begin
                chk("wr_rdv_early", {30'd0, r_data_rdv, r_instr_rdv}, 32'd0);
                tick();
                rd = (i == 0) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i));
                mem_rdata = rd;
                rdv_force = 1'b1;
                #1;
                chk("rdv_route", {30'd0, r_data_rdv, r_instr_rdv}, {30'd0, onehot});
                chk("rdata", e ? r_data_rdata : r_instr_rdata, rd);
                tick();
                rdv_force = 1'b0;
                #1;
                chk("rdv_single_pulse", {30'd0, r_data_rdv, r_instr_rdv}, 32'd0);
            end
            chk("no_bus_error", {31'd0, r_bus_error}, 32'd0);
            $display("vec %0d grant=%0d rd=%0d wr=%0d addr=%h", i, e, vt[i].erd, vt[i].ewr, vt[i].ea);
            tick();
        end

        // Data write with slave stalling three cycles
        mem_wait = 1'b1;
        data_write = 1'b1;
        data_address = 32'h2000;
        data_byteenable = 4'hF;
        data_host_to_agent = 32'h12345678;
        tick();
        stable = 0;
        low = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_wait = 1'b0;
            #1;
            if (r_mem_write && !r_mem_read && r_mem_addr == 32'h2000 &&
                r_mem_be == 4'hF && r_mem_wdata == 32'h12345678) stable++;
            if (!r_data_wait) low++;
            tick();
        end
        drop_all();
        #1;
        chk("stall_stable_cycles", stable, 32'd4);
        chk("stall_wait_low_cycles", low, 32'd1);
        chk("stall_back_idle", {30'd0, r_mem_write, r_data_wait}, 32'd1);
        $display("stalled write stable=%0d wait_low=%0d", stable, low);
        tick();

        // Stray read data valid in IDLE
        mem_rdata = 32'h55555555;
        rdv_force = 1'b1;
        #1;
        chk("stray_no_rdv", {30'd0, r_data_rdv, r_instr_rdv}, 32'd0);
        tick();
        rdv_force = 1'b0;
        #1;
        chk("stray_bus_error", {31'd0, r_bus_error}, 32'd1);
        repeat (3) tick();
        chk("bus_error_sticky", {31'd0, r_bus_error}, 32'd1);
        $display("stray beat bus_error=%0d", r_bus_error);

        // Reset asserted mid-ISSUE while bus_error is set
        mem_wait = 1'b1;
        instr_read = 1'b1;
        instr_address = 32'h100;
        instr_byteenable = 4'hF;
        tick();
        chk("pre_reset_issue", {31'd0, r_mem_read}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_strobes", {30'd0, r_mem_read, r_mem_write}, 32'd0);
        chk("rst_mid_addr_be", r_mem_addr | {28'd0, r_mem_be} | r_mem_wdata, 32'd0);
        chk("rst_mid_wait", {30'd0, r_instr_wait, r_data_wait}, 32'd3);
        chk("rst_mid_bus_error", {31'd0, r_bus_error}, 32'd0);
        $display("reset mid-issue strobes=%0d%0d err=%0d", r_mem_read, r_mem_write, r_bus_error);
        drop_all();
        mem_wait = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Reset abandons an outstanding read; late beat is stray
        instr_read = 1'b1;
        tick();
        tick();
        drop_all();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rdv_force = 1'b1;
        #1;
        chk("late_beat_no_rdv", {30'd0, r_data_rdv, r_instr_rdv}, 32'd0);
        tick();
        rdv_force = 1'b0;
        #1;
        chk("late_beat_bus_error", {31'd0, r_bus_error}, 32'd1);
        $display("abandoned read late beat err=%0d", r_bus_error);
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Continuous contention on both instances
        q_rr.delete();
        auto_en = 1'b1;
        mem_wait = 1'b0;
        for (int k = 0; k < 6; k++) begin
            q_rr.push_back(k[0] ? 1'b0 : 1'b1);
            q_fp.push_back(1'b1);
        end
        instr_read = 1'b1;
        instr_address = 32'h1000;
        instr_byteenable = 4'hF;
        data_write = 1'b1;
        data_address = 32'h2000;
        data_byteenable = 4'hF;
        data_host_to_agent = 32'h33;
        n_rr = 0;
        n_fp = 0;
        for (int cyc = 0; cyc < 80 && (n_rr < 6 || n_fp < 6); cyc++) begin
            #1;
            if ((r_mem_read || r_mem_write) && n_rr < 6 && q_rr.size() > 0) begin
                e = q_rr.pop_front();
                onehot = e ? 2'b10 : 2'b01;
                chk("rr_grant", {30'd0, obs_r()}, {30'd0, onehot});
                $display("rr grant %0d got=%b want=%b", n_rr, obs_r(), onehot);
                n_rr++;
            end
            if ((f_mem_read || f_mem_write) && n_fp < 6 && q_fp.size() > 0) begin
                e = q_fp.pop_front();
                onehot = e ? 2'b10 : 2'b01;
                chk("fp_grant", {30'd0, ~f_data_wait, ~f_instr_wait}, {30'd0, onehot});
                $display("fp grant %0d got=%b want=%b", n_fp, {~f_data_wait, ~f_instr_wait}, onehot);
                n_fp++;
            end
            tick();
        end
        chk("rr_grant_count", n_rr, 32'd6);
        chk("fp_grant_count", n_fp, 32'd6);
        drop_all();
        auto_en = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
